// File: rtl/muldiv4_seq.sv
// Iterative WIDTH-bit shift-add multiplier / restoring divider that shares one add/subtract chain.
// Define MULDIV4_DIV_EN to compile in the divide path, its error checks and the err flag.
module muldiv4_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic [1:0]           dbgState
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or DONE);
  // done is a one-cycle pulse and result/err hold until the next done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH:0]     acc;
  logic [WIDTH-1:0]     bReg;

  logic [WIDTH:0]       addX;
  logic [WIDTH:0]       addY;
  logic                 addCin;
  logic [WIDTH+1:0]     addSum;
  logic [2*WIDTH:0]     accNext;
  logic [2*WIDTH-1:0]   finalResult;

  // Shared chain: plain add for multiply, x + ~y + 1 for the divide trial subtraction.
  assign addSum  = {1'b0, addX} + {1'b0, addY} + {{(WIDTH+1){1'b0}}, addCin};
  assign accNext = acc[0] ? ({addSum[WIDTH:0], acc[WIDTH-1:0]} >> 1) : (acc >> 1);

  assign dbgState = state;

`ifdef MULDIV4_DIV_EN
  logic                 opReg;
  logic                 errReg;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     q;
  logic [WIDTH:0]       remShift;
  logic [WIDTH-1:0]     remNext;
  logic [WIDTH-1:0]     qNext;
  logic                 noBorrow;
  logic                 divZero;
  logic                 divOvf;

  // Remainder stays below the divisor, so the restored or reduced value always fits WIDTH bits.
  assign remShift = {rem, q[WIDTH-1]};
  assign noBorrow = addSum[WIDTH+1];
  assign remNext  = noBorrow ? addSum[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign qNext    = {q[WIDTH-2:0], noBorrow};
  assign divZero  = (b == '0);
  assign divOvf   = (a[2*WIDTH-1:WIDTH] >= b);

  always_comb begin
    addX   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    addY   = {1'b0, bReg};
    addCin = 1'b0;
    if (opReg) begin
      addX   = remShift;
      addY   = ~{1'b0, bReg};
      addCin = 1'b1;
    end
  end

  assign finalResult = opReg ? {remNext, qNext} : accNext[2*WIDTH-1:0];
  assign err         = errReg;
`else
  logic unusedInputs;

  assign unusedInputs = ^{op, a[2*WIDTH-1:WIDTH], addSum[WIDTH+1]};

  always_comb begin
    addX   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    addY   = {1'b0, bReg};
    addCin = 1'b0;
  end

  assign finalResult = accNext[2*WIDTH-1:0];
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      bReg   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef MULDIV4_DIV_EN
      opReg  <= 1'b0;
      errReg <= 1'b0;
      rem    <= '0;
      q      <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            cnt  <= '0;
            bReg <= b;
            acc  <= {{(WIDTH+1){1'b0}}, a[WIDTH-1:0]};
`ifdef MULDIV4_DIV_EN
            opReg <= op;
            rem   <= a[2*WIDTH-1:WIDTH];
            q     <= a[WIDTH-1:0];
            // Errors are decided from the raw inputs and skip RUN entirely.
            if (op && (divZero || divOvf)) begin
              state  <= DONE;
              done   <= 1'b1;
              errReg <= 1'b1;
              result <= divZero ? {a[WIDTH-1:0], {WIDTH{1'b1}}} : {(2*WIDTH){1'b1}};
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= accNext;
`ifdef MULDIV4_DIV_EN
          rem <= remNext;
          q   <= qNext;
`endif
          if (cnt == CW'(WIDTH-1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= finalResult;
`ifdef MULDIV4_DIV_EN
            errReg <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv4_seq.sv
// Self-checking bench for muldiv4_seq: arithmetic reference model, expected queue, per-cycle compare.
// Honours MULDIV4_DIV_EN the same way as the design.
module tb_muldiv4_seq;

  localparam int W = 4;
`ifdef MULDIV4_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             op;
  logic [2*W-1:0]   a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   result;
  logic             err;
  logic [1:0]       dbgState;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             due;
  } exp_t;

  exp_t           expQ[$];
  exp_t           curE;
  int             cyc = 0;
  int             busyFirst = 1;
  int             busyLast = 0;
  int             nChecks = 0;
  int             nFail = 0;
  logic [2*W-1:0] lastRes = '0;
  logic           lastErr = 1'b0;
  logic           expBusy;

  muldiv4_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err),
    .dbgState (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Returns {err, result} from the arithmetic definition of each operation.
  function automatic logic [2*W:0] modelCalc(input logic o, input logic [2*W-1:0] av,
                                             input logic [W-1:0] bv);
    int p;
    int hi;
    hi = int'(av[2*W-1:W]);
    if (DIV_EN && o) begin
      if (bv == '0) return {1'b1, av[W-1:0], {W{1'b1}}};
      if (hi >= int'(bv)) return {1'b1, {(2*W){1'b1}}};
      p = (int'(av) % int'(bv)) * (1 << W) + int'(av) / int'(bv);
      return {1'b0, p[2*W-1:0]};
    end
    p = int'(av[W-1:0]) * int'(bv);
    return {1'b0, p[2*W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
    end else begin
      expBusy = (cyc >= busyFirst) && (cyc <= busyLast);
      chk("busy", 32'(busy), 32'(expBusy));
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
        curE = expQ.pop_front();
        chk("done_pulse", 32'(done), 32'd1);
        chk("result", 32'(result), 32'(curE.res));
        chk("err", 32'(err), 32'(curE.err));
        lastRes = curE.res;
        lastErr = curE.err;
      end else begin
        chk("no_done", 32'(done), 32'd0);
        chk("result_hold", 32'(result), 32'(lastRes));
        chk("err_hold", 32'(err), 32'(lastErr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic gotoCyc(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic issue(input logic o, input logic [2*W-1:0] av, input logic [W-1:0] bv,
                       output int due);
    int k;
    logic [2*W:0] m;
    k = cyc;
    due = -1;
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    if (!((k >= busyFirst) && (k <= busyLast))) begin
      m = modelCalc(o, av, bv);
      if (m[2*W]) begin
        due = k + 1;
      end else begin
        due = k + W + 1;
        busyFirst = k + 1;
        busyLast = k + W;
      end
      expQ.push_back('{res: m[2*W-1:0], err: m[2*W], due: due});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic randIssue(output int due);
    logic o;
    logic [2*W-1:0] av;
    logic [W-1:0] bv;
    o = 1'($urandom_range(0, 1));
    bv = W'($urandom_range(0, (1 << W) - 1));
    av = (2*W)'($urandom_range(0, (1 << (2*W)) - 1));
    if (o && bv != '0 && $urandom_range(0, 3) != 0)
      av[2*W-1:W] = W'($urandom_range(0, int'(bv) - 1));
    issue(o, av, bv, due);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d;
    int d2;
    int mode;
    rst_n = 1'b0;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    tick(3);
    chk("rst_state_busy", 32'(busy), 32'd0);
    chk("rst_state_done", 32'(done), 32'd0);
    chk("rst_state_result", 32'(result), 32'd0);
    chk("rst_state_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Hand-computed values that pin the model.
    chk("model_mul_15x15", 32'(modelCalc(1'b0, 8'd15, 4'd15)), 32'h0E1);
    chk("model_mul_7x3", 32'(modelCalc(1'b0, 8'd7, 4'd3)), 32'd21);
    if (DIV_EN) begin
      chk("model_div_200_15", 32'(modelCalc(1'b1, 8'd200, 4'd15)), 32'h05D);
      chk("model_div_zero", 32'(modelCalc(1'b1, 8'h23, 4'd0)), 32'h13F);
      chk("model_div_ovf", 32'(modelCalc(1'b1, 8'hF0, 4'd3)), 32'h1FF);
    end else begin
      chk("model_nodiv_6_5", 32'(modelCalc(1'b1, 8'd6, 4'd5)), 32'd30);
    end

    // Directed cases.
    issue(1'b0, 8'd15, 4'd15, d);
    gotoCyc(d);
    tick(2);
    issue(1'b0, 8'd0, 4'd9, d);
    gotoCyc(d);
    issue(1'b0, 8'd7, 4'd3, d);
    gotoCyc(d);
    tick(1);
    issue(1'b1, 8'd200, 4'd15, d);
    gotoCyc(d);
    tick(1);
    issue(1'b1, 8'h23, 4'd0, d);
    gotoCyc(d);
    tick(1);
    issue(1'b1, 8'hF0, 4'd3, d);
    gotoCyc(d);
    tick(1);
    issue(1'b1, 8'd6, 4'd5, d);
    gotoCyc(d);
    tick(1);

    // Start during RUN must be ignored.
    issue(1'b0, 8'd13, 4'd11, d);
    issue(1'b1, 8'd2, 4'd2, d2);
    chk("ignored_start", 32'(d2), 32'hFFFF_FFFF);
    gotoCyc(d);
    tick(1);

    // Asynchronous reset mid-RUN aborts without done.
    issue(1'b0, 8'd15, 4'd13, d);
    tick(1);
    rst_n = 1'b0;
    expQ.delete();
    busyFirst = 1;
    busyLast = 0;
    lastRes = '0;
    lastErr = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    issue(1'b0, 8'd6, 4'd5, d);
    gotoCyc(d);
    tick(1);

    // Randomized traffic: back-to-back, ignored starts and idle gaps.
    for (int i = 0; i < 80; i++) begin
      randIssue(d);
      mode = int'($urandom_range(0, 2));
      if (mode == 1) begin
        randIssue(d2);
        if (d2 > d) d = d2;
      end
      gotoCyc(d);
      if (mode == 2) tick(int'($urandom_range(1, 2)));
    end

    tick(3);
    chk("queue_empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/muldiv4_seq.md
# muldiv4_seq

Iterative 4-bit multiply/divide sequencer for the muldiv4 datapath. It accepts operands and an opcode, steps the shared half-adder/full-adder add/subtract chain once per cycle, and accumulates the shift-add product or the restoring-division quotient and remainder. It registers the result for the output stage. It sits directly upstream of the adder cells, driving their operands, and consumes their sum and carry outputs.

## Interface
- `WIDTH`, default 4: operand width. The product and dividend are 2·WIDTH bits. The iteration count equals WIDTH.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request pulse; sampled only when `busy`=0.
- `op`  in  1  operation select: 0 = multiply, 1 = divide.
- `a`  in  2·WIDTH  operand A.
  - Multiply: multiplicand is `a[WIDTH-1:0]`; upper bits are ignored.
  - Divide: `a` is the full dividend.
- `b`  in  WIDTH  multiplier or divisor.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when `result` and `err` become valid.
- `result`  out  2·WIDTH  output value.
  - Multiply: the product.
  - Divide: {remainder, quotient}.
- `err`  out  1  divide-by-zero or quotient overflow; valid with `done`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: iterates for WIDTH cycles.
  - DONE: lasts one cycle; `done`=1.
- IDLE/DONE + `start`=1:
  - Latch `op`, `a`, `b`, and clear the iteration counter.
  - Go to RUN, or go straight to DONE on an error (see below).
- RUN, counter < WIDTH-1: increment the counter and stay in RUN.
- RUN, counter = WIDTH-1: write `result`, then go to DONE.
- DONE, `start`=0: go to IDLE.
- `start` while `busy`=1 is ignored. Latched operands never change mid-operation.
- Multiply (shift-add):
  - Initialise acc[2W:0] = {0, a[W-1:0]}.
  - Each cycle: if acc[0]=1, then acc[2W:W] = acc[2W-1:W] + b, using a (W+1)-bit sum including the carry-out. Then shift acc right by 1.
  - After WIDTH cycles, product = acc[2W-1:0]. Multiply never sets `err`.
- Divide (restoring):
  - Initialise rem[W:0] = {0, a[2W-1:W]} and q = a[W-1:0].
  - Each cycle: shift {rem, q} left by 1, then compute t = rem − {0,b}.
  - No borrow: rem = t and q[0] = 1. Otherwise rem is restored and q[0] = 0.
  - After WIDTH cycles, result = {rem[W-1:0], q}.
- Error checks, evaluated at the `start` sample when op=1:
  - b=0 → `err`=1, `result`={a[W-1:0], all ones}.
  - a[2W-1:W] ≥ b (quotient overflow) → `err`=1, `result`=all ones.
  - In both cases there is no RUN phase; `done` is asserted the next cycle.
- `result`/`err` hold their value until the next `done`.

## Timing
- Reset (async, `rst_n`=0): state=IDLE; `busy`=0, `done`=0, `result`=0, `err`=0; counter and accumulators are 0.
- Reset asserted mid-RUN aborts immediately. No `done` is produced.
- `start` is sampled at edge N.
  - `busy`=1 during cycles N+1 … N+WIDTH.
  - `done`=1 and `result` valid in cycle N+WIDTH+1, with `busy`=0.
  - Latency is WIDTH+1 cycles (5 for the default).
- Error path: `done`=1 in cycle N+1; `busy` stays 0.
- Back-to-back: `start`=1 during the DONE cycle is accepted. The next `done` comes WIDTH+1 cycles later, with no idle gap.
- `result` and `err` update only on the edge that enters DONE. They are registered outputs with no combinational path from the inputs.

## Configuration
- `MULDIV4_DIV_EN` defined: divide path, error checks and `err` logic are compiled in.
- Not defined:
  - `op` is ignored and every request is a multiply.
  - `err` is tied to 0.
  - The divide/restore logic is absent.
  - Multiply timing is unchanged.

## Test plan
- Multiply: op=0, a=15, b=15, `start` at N → `done` at N+5, `result`=225 (0xE1), `err`=0; `busy` high for exactly 4 cycles.
- Multiply by zero, back-to-back:
  - op=0, a=0, b=9 → `result`=0.
  - `start` asserted again in the DONE cycle with a=7, b=3 → next `done` 5 cycles later with `result`=21.
- Divide: op=1, a=200, b=15 → `done` at N+5, quotient=13, remainder=5, `result`=0x5D, `err`=0.
- Divide errors:
  - op=1, a=0x23, b=0 → `done` at N+1, `err`=1, `result`=0x3F.
  - op=1, a=0xF0, b=3 → `done` at N+1, `err`=1, `result`=0xFF.
- Busy and reset:
  - `start` with new operands pulsed during RUN → ignored; the original result is delivered.
  - `rst_n` pulsed low mid-RUN → all outputs 0 immediately; no `done`; the next `start` works normally.
- Configuration build without `MULDIV4_DIV_EN`: op=1, a=6, b=5 → `result`=30, `err`=0.
